// File: rtl/correlation_packetizer_pkg.sv
// Shared constants for the correlation packetizer: FSM state encoding,
// frame sync words and the end-of-line byte values.
package correlation_packetizer_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HEADER  = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_FOOTER  = 3'd3;
    localparam logic [2:0] ST_EOL_CR  = 3'd4;
    localparam logic [2:0] ST_EOL_LF  = 3'd5;

    // Frame sync words
    localparam logic [15:0] SYNC_HDR = 16'hAA55;
    localparam logic [31:0] SYNC_FTR = 32'h55AA55AA;

    // End-of-line bytes
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/correlation_packetizer_if.sv
// Byte stream towards the UART transmitter.
//   tx_data  : ASCII byte
//   tx_valid : tx_data holds a byte
//   tx_ready : sink accepts the byte (transfer when valid & ready)
// master = packetizer side, slave = UART side.
interface correlation_packetizer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/correlation_packetizer_hex_ascii.sv
// hex_ascii: converts one nibble to its uppercase ASCII hex character.
//   nib_i   : 4-bit value
//   ascii_o : '0'..'9' (8'h30..8'h39) or 'A'..'F' (8'h41..8'h46)
// Purely combinational.
module correlation_packetizer_hex_ascii (
    input  logic [3:0] nib_i,
    output logic [7:0] ascii_o
);
    always_comb begin
        if (nib_i < 4'd10) ascii_o = 8'h30 + {4'h0, nib_i};
        else               ascii_o = 8'h37 + {4'h0, nib_i};
    end
endmodule

// File: rtl/correlation_packetizer.sv
// correlation_packetizer: on a capture request, snapshots the correlator
// accumulators, asks the correlator to clear them, and streams one ASCII
// frame (hex header, hex payload words, hex footer with XOR checksum, CR LF)
// over a valid/ready byte interface.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   pulses     : CORR_WORDS accumulators of RESOLUTION bits, word k at [k*RESOLUTION +: RESOLUTION]
//   capture    : single-cycle frame request
//   acc_clear  : one-cycle pulse after an accepted capture
//   busy       : a frame is in flight
//   overrun    : sticky, a capture arrived while busy
//   tx         : byte stream (master side)
module correlation_packetizer
    import correlation_packetizer_pkg::*;
#(
    parameter int NUM_BASELINES = 1,
    parameter int LAG_CROSS     = 1,
    parameter int RESOLUTION    = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic [NUM_BASELINES*(2*LAG_CROSS-1)*2*RESOLUTION-1:0] pulses,
    input  logic capture,
    output logic acc_clear,
    output logic busy,
    output logic overrun,
    correlation_packetizer_if.master tx
);
    localparam int CORR_WORDS = NUM_BASELINES * (2 * LAG_CROSS - 1) * 2;
    localparam int NIB        = (RESOLUTION + 3) / 4;
    localparam int NIB_W      = NIB * 4;
    localparam int WORD_W     = (CORR_WORDS > 1) ? $clog2(CORR_WORDS) : 1;
    localparam int SNAP_W     = CORR_WORDS * RESOLUTION;

    logic [2:0]        state_q, state_d;
    logic [3:0]        idx_q, idx_d;      // nibble index, counts down
    logic [WORD_W-1:0] word_q, word_d;    // payload word index, counts down
    logic [31:0]       frame_q, frame_d;
    logic [SNAP_W-1:0] snap_q;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              acc_clear_q, overrun_q;

    logic              start, xfer;
    logic [31:0]       csum;
    logic [63:0]       hdr_word, ftr_word;
    logic [NIB_W-1:0]  word_ext;
    logic [3:0]        nib;
    logic [7:0]        hex_char;

    assign busy        = (state_q != ST_IDLE);
    assign xfer        = tx_valid_q & tx.tx_ready;
    assign start       = capture & ~busy;
    assign acc_clear   = acc_clear_q;
    assign overrun     = overrun_q;
    assign tx.tx_valid = tx_valid_q;
    assign tx.tx_data  = tx_data_q;

    // Checksum over the frozen snapshot, each word zero-extended to 32 bits.
    always_comb begin
        csum = '0;
        for (int k = 0; k < CORR_WORDS; k++)
            csum = csum ^ 32'(snap_q[k*RESOLUTION +: RESOLUTION]);
    end

    // Pointer advance: the pointer always names the byte held in tx_data_q,
    // so it moves on an accepted byte and the next byte is loaded on the
    // same edge, giving one byte per cycle across state boundaries.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        word_d     = word_q;
        frame_d    = frame_q;
        tx_valid_d = tx_valid_q;
        if (start) begin
            state_d    = ST_HEADER;
            idx_d      = 4'd15;
            word_d     = '0;
            frame_d    = frame_q + 32'd1;
            tx_valid_d = 1'b1;
        end else if (xfer) begin
            case (state_q)
                ST_HEADER: begin
                    if (idx_q == 4'd0) begin
                        state_d = ST_PAYLOAD;
                        word_d  = WORD_W'(CORR_WORDS - 1);
                        idx_d   = 4'(NIB - 1);
                    end else idx_d = idx_q - 4'd1;
                end
                ST_PAYLOAD: begin
                    if (idx_q == 4'd0) begin
                        if (word_q == '0) begin
                            state_d = ST_FOOTER;
                            idx_d   = 4'd15;
                        end else begin
                            word_d = word_q - 1'b1;
                            idx_d  = 4'(NIB - 1);
                        end
                    end else idx_d = idx_q - 4'd1;
                end
                ST_FOOTER: begin
                    if (idx_q == 4'd0) state_d = ST_EOL_CR;
                    else               idx_d   = idx_q - 4'd1;
                end
                ST_EOL_CR: state_d = ST_EOL_LF;
                default: begin
                    state_d    = ST_IDLE;
                    tx_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Byte for the next pointer position. The header uses frame_d so the
    // post-increment count appears in the frame that bumped it; payload and
    // footer only occur while busy, when the snapshot is stable.
    always_comb begin
        hdr_word = {SYNC_HDR, 16'(CORR_WORDS), frame_d};
        ftr_word = {SYNC_FTR, csum};
        word_ext = NIB_W'(snap_q[word_d*RESOLUTION +: RESOLUTION]);
        case (state_d)
            ST_HEADER:  nib = hdr_word[idx_d*4 +: 4];
            ST_PAYLOAD: nib = word_ext[idx_d*4 +: 4];
            ST_FOOTER:  nib = ftr_word[idx_d*4 +: 4];
            default:    nib = 4'h0;
        endcase
    end

    correlation_packetizer_hex_ascii u_hex_ascii (
        .nib_i   (nib),
        .ascii_o (hex_char)
    );

    always_comb begin
        tx_data_d = tx_data_q;
        if (start || xfer) begin
            case (state_d)
                ST_EOL_CR: tx_data_d = ASCII_CR;
                ST_EOL_LF: tx_data_d = ASCII_LF;
                ST_IDLE:   tx_data_d = tx_data_q;
                default:   tx_data_d = hex_char;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= 4'd0;
            word_q      <= '0;
            frame_q     <= 32'd0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            acc_clear_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            frame_q     <= frame_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            acc_clear_q <= start;
            if (capture && busy) overrun_q <= 1'b1;
        end
    end

    // Snapshot is pure data: no reset, loaded only on an accepted capture.
    always_ff @(posedge clk) begin
        if (start && !reset) snap_q <= pulses;
    end

endmodule

// File: tb/tb_correlation_packetizer.sv
// Testbench for correlation_packetizer: two instances (RESOLUTION=8 and 10,
// both with CORR_WORDS=2). Expected byte streams are queued when a capture
// is issued; monitors pop and compare on every valid&ready byte.
module tb_correlation_packetizer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, cap8, cap10;
    logic [15:0] pulses8;
    logic [19:0] pulses10;
    logic        ac8, busy8, ovr8, ac10, busy10, ovr10;

    correlation_packetizer_if tx8();
    correlation_packetizer_if tx10();

    correlation_packetizer #(.NUM_BASELINES(1), .LAG_CROSS(1), .RESOLUTION(8)) u_dut8 (
        .clk(clk), .reset(reset), .pulses(pulses8), .capture(cap8),
        .acc_clear(ac8), .busy(busy8), .overrun(ovr8), .tx(tx8.master)
    );

    correlation_packetizer #(.NUM_BASELINES(1), .LAG_CROSS(1), .RESOLUTION(10)) u_dut10 (
        .clk(clk), .reset(reset), .pulses(pulses10), .capture(cap10),
        .acc_clear(ac10), .busy(busy10), .overrun(ovr10), .tx(tx10.master)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;
    int cnt8     = 0;
    int cnt10    = 0;
    int last8    = 0;
    int ac_cnt   = 0;
    bit bp_en    = 1'b0;
    logic        hold8 = 1'b0;
    logic [7:0]  hold_data = 8'h00;
    logic [7:0]  q8[$];
    logic [7:0]  q10[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Random backpressure on the 8-bit instance
    always @(posedge clk) begin
        if (bp_en) begin
            #1;
            tx8.tx_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor / scoreboard, RESOLUTION=8 instance
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (hold8) begin
            chk("hold_valid", 64'(tx8.tx_valid), 64'd1);
            chk("hold_data", 64'(tx8.tx_data), 64'(hold_data));
        end
        hold8     = tx8.tx_valid & ~tx8.tx_ready & ~reset;
        hold_data = tx8.tx_data;
        if (ac8) ac_cnt++;
        if (tx8.tx_valid && tx8.tx_ready && !reset) begin
            if (q8.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx8_unexpected: got byte %02h, expected no byte", tx8.tx_data);
            end else begin
                exp_b = q8.pop_front();
                chk("rx8_byte", 64'(tx8.tx_data), 64'(exp_b));
            end
            cnt8++;
            last8 = cyc_n;
        end
    end

    // Monitor / scoreboard, RESOLUTION=10 instance
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (tx10.tx_valid && tx10.tx_ready && !reset) begin
            if (q10.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx10_unexpected: got byte %02h, expected no byte", tx10.tx_data);
            end else begin
                exp_b = q10.pop_front();
                chk("rx10_byte", 64'(tx10.tx_data), 64'(exp_b));
            end
            cnt10++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_frame8(input string h, input string p, input string f);
        string s;
        s = {h, p, f};
        for (int i = 0; i < s.len(); i++) q8.push_back(s[i]);
        q8.push_back(8'h0D);
        q8.push_back(8'h0A);
    endtask

    task automatic push_frame10(input string h, input string p, input string f);
        string s;
        s = {h, p, f};
        for (int i = 0; i < s.len(); i++) q10.push_back(s[i]);
        q10.push_back(8'h0D);
        q10.push_back(8'h0A);
    endtask

    task automatic capture8();
        cap8 = 1'b1;
        cyc(1);
        cap8 = 1'b0;
    endtask

    task automatic wait_idle8(input string name);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (q8.size() == 0 && !busy8) break;
        end
        chk(name, 64'(q8.size()), 64'd0);
        chk("idle8_busy", 64'(busy8), 64'd0);
        cyc(1);
    endtask

    task automatic wait_idle10(input string name);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (q10.size() == 0 && !busy10) break;
        end
        chk(name, 64'(q10.size()), 64'd0);
        chk("idle10_busy", 64'(busy10), 64'd0);
        cyc(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, c0, acb;
        reset        = 1'b1;
        cap8         = 1'b0;
        cap10        = 1'b0;
        pulses8      = 16'h0000;
        pulses10     = 20'h0;
        tx8.tx_ready = 1'b1;
        tx10.tx_ready = 1'b1;
        cyc(3);
        // capture together with reset is ignored
        cap8 = 1'b1;
        cyc(1);
        cap8  = 1'b0;
        reset = 1'b0;
        cyc(1);
        chk("rst_valid", 64'(tx8.tx_valid), 64'd0);
        chk("rst_data", 64'(tx8.tx_data), 64'h00);
        chk("rst_acc_clear", 64'(ac8), 64'd0);
        chk("rst_busy", 64'(busy8), 64'd0);
        chk("rst_overrun", 64'(ovr8), 64'd0);
        chk("rst_valid10", 64'(tx10.tx_valid), 64'd0);

        // Basic frame, tx_ready held high
        pulses8 = 16'h1234;
        push_frame8("AA55000200000001", "1234", "55AA55AA00000026");
        base = cnt8;
        acb  = ac_cnt;
        capture8();
        c0 = cyc_n;
        @(negedge clk);
        chk("first_valid", 64'(tx8.tx_valid), 64'd1);
        chk("first_char", 64'(tx8.tx_data), 64'h41);
        chk("acc_clear_pulse", 64'(ac8), 64'd1);
        chk("busy_frame", 64'(busy8), 64'd1);
        @(negedge clk);
        chk("acc_clear_single", 64'(ac8), 64'd0);
        wait_idle8("basic_done");
        chk("basic_bytes", 64'(cnt8 - base), 64'd38);
        chk("basic_no_bubble", 64'(last8 - c0), 64'd37);
        chk("basic_acc_clear_cnt", 64'(ac_cnt - acb), 64'd1);

        // Random backpressure
        push_frame8("AA55000200000002", "1234", "55AA55AA00000026");
        bp_en = 1'b1;
        capture8();
        wait_idle8("bp_done");
        bp_en = 1'b0;
        cyc(1);
        tx8.tx_ready = 1'b1;

        // RESOLUTION=10: 3 nibbles per word
        pulses10 = {10'h3FF, 10'h001};
        push_frame10("AA55000200000001", "3FF001", "55AA55AA000003FE");
        base  = cnt10;
        cap10 = 1'b1;
        cyc(1);
        cap10 = 1'b0;
        wait_idle10("res10_done");
        chk("res10_bytes", 64'(cnt10 - base), 64'd40);

        // Reset after the 10th byte aborts the frame
        push_frame8("AA55000200000003", "1234", "55AA55AA00000026");
        base = cnt8;
        capture8();
        for (int k = 0; k < 200; k++) begin
            if (cnt8 - base >= 10) break;
            cyc(1);
        end
        reset        = 1'b1;
        tx8.tx_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_valid", 64'(tx8.tx_valid), 64'd0);
        chk("abort_busy", 64'(busy8), 64'd0);
        chk("abort_bytes", 64'(cnt8 - base), 64'd10);
        q8.delete();
        cyc(1);
        reset        = 1'b0;
        tx8.tx_ready = 1'b1;

        // Frame after reset restarts at 1; pulses change mid-frame; capture
        // 5 cycles later is dropped and sets overrun
        pulses8 = 16'h1234;
        push_frame8("AA55000200000001", "1234", "55AA55AA00000026");
        capture8();
        cyc(1);
        pulses8 = 16'hFFFF;
        cyc(3);
        cap8 = 1'b1;
        cyc(1);
        cap8 = 1'b0;
        @(negedge clk);
        chk("ovr_no_clear", 64'(ac8), 64'd0);
        chk("ovr_flag", 64'(ovr8), 64'd1);
        wait_idle8("ovr_done");
        chk("ovr_sticky", 64'(ovr8), 64'd1);
        pulses8 = 16'h1234;
        push_frame8("AA55000200000002", "1234", "55AA55AA00000026");
        capture8();
        wait_idle8("ovr_next_done");

        // Capture on the cycle of the final LF transfer is dropped
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        chk("rst2_overrun", 64'(ovr8), 64'd0);
        push_frame8("AA55000200000001", "1234", "55AA55AA00000026");
        capture8();
        cyc(37);
        cap8 = 1'b1;
        cyc(1);
        cap8 = 1'b0;
        @(negedge clk);
        chk("eol_cap_busy", 64'(busy8), 64'd0);
        chk("eol_cap_valid", 64'(tx8.tx_valid), 64'd0);
        chk("eol_cap_clear", 64'(ac8), 64'd0);
        chk("eol_cap_overrun", 64'(ovr8), 64'd1);
        wait_idle8("eol_done");
        push_frame8("AA55000200000002", "1234", "55AA55AA00000026");
        capture8();
        wait_idle8("eol_next_done");

        cyc(5);
        chk("final_q8", 64'(q8.size()), 64'd0);
        chk("final_q10", 64'(q10.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/correlation_packetizer.md
CORRELATION_PACKETIZER -- requirements
Module: correlation_packetizer

Interface
REQ-001 Parameter NUM_BASELINES, default 1, number of correlated input pairs.
REQ-002 Parameter LAG_CROSS, default 1, one-sided cross lag; CORR_WORDS = NUM_BASELINES*(2*LAG_CROSS-1)*2.
REQ-003 Parameter RESOLUTION, default 24, bits per accumulator word, range 4..32.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 pulses  input  CORR_WORDS*RESOLUTION  live correlator accumulators; word k = pulses[k*RESOLUTION+:RESOLUTION].
REQ-007 capture  input  1  single-cycle frame request.
REQ-008 acc_clear  output  1  one-cycle pulse telling the correlator to zero its accumulators.
REQ-009 tx_data  output  8  ASCII byte to UART transmitter.
REQ-010 tx_valid  output  1  tx_data holds a byte.
REQ-011 tx_ready  input  1  UART accepts the byte; a transfer occurs on a cycle with tx_valid & tx_ready both high.
REQ-012 busy  output  1  high from snapshot until the last byte is transferred.
REQ-013 overrun  output  1  sticky: a capture arrived while busy.

Function
REQ-014 On capture with busy low, the block SHALL latch pulses into a snapshot register and increment the 32-bit frame counter on that same edge; acc_clear SHALL be high the following cycle only.
REQ-015 tx_valid SHALL rise one cycle after the capture edge, carrying the first header character.
REQ-016 FSM states: IDLE, HEADER, PAYLOAD, FOOTER, EOL_CR, EOL_LF. Transition on the final accepted byte of each state; EOL_LF returns to IDLE.
REQ-017 Header is 64 bits {16'hAA55, CORR_WORDS[15:0], frame_count[31:0]}, where frame_count is the post-increment value; it is sent as 16 hex characters, MSB nibble first.
REQ-018 Payload: words CORR_WORDS-1 down to 0; each word is sent as NIB=ceil(RESOLUTION/4) hex characters, MSB first, with the word zero-extended to NIB*4 bits.
REQ-019 Footer is 64 bits {32'h55AA55AA, checksum}; checksum is the XOR of all payload words, each zero-extended to 32 bits, and is computed from the snapshot.
REQ-020 EOL_CR sends 8'h0D; EOL_LF sends 8'h0A.
REQ-021 Hex encoding is uppercase ASCII: 0-9 map to 8'h30-8'h39, A-F map to 8'h41-8'h46.
REQ-022 While tx_valid is high and tx_ready is low, tx_data SHALL remain stable; tx_valid SHALL never drop without a transfer.
REQ-023 Back-to-back: with tx_ready held high, one byte SHALL be transferred per cycle with no bubbles, including across state boundaries.
REQ-024 A capture while busy SHALL be ignored: no snapshot, no counter change, no acc_clear. It sets overrun.
REQ-025 A capture on the same cycle as the final EOL_LF transfer counts as busy and is dropped.
REQ-026 Total bytes per frame = 16 + CORR_WORDS*NIB + 16 + 2.
REQ-027 The frame counter wraps from 32'hFFFFFFFF to 0 silently.

Reset
REQ-028 Reset outputs: tx_valid=0, tx_data=8'h00, acc_clear=0, busy=0, overrun=0.
REQ-029 Reset sets FSM=IDLE, frame counter=0, and clears all indices.
REQ-030 Reset mid-frame SHALL abort the frame: tx_valid is low the next cycle, and no footer or EOL is sent.
REQ-031 A capture asserted together with reset SHALL be ignored.

Structure
REQ-032 A shared package holds the state enumeration, the sync constants 16'hAA55 and 32'h55AA55AA, and the CR/LF byte constants.
REQ-033 Sub-module hex_ascii: 4-bit nibble to 8-bit ASCII, purely combinational.
REQ-034 Snapshot is a flat register; nibble selection uses a word index and a nibble index counter, with no barrel shifting of the full bus.

Verification (NUM_BASELINES=1, LAG_CROSS=1, RESOLUTION=8, so CORR_WORDS=2)
REQ-035 Basic frame: pulses=16'h1234, tx_ready=1, one capture -> the bench receives "AA55000200000001" "1234" "55AA55AA00000026" 0D 0A, 38 bytes in 38 consecutive cycles, and acc_clear is seen once.
REQ-036 Backpressure: tx_ready toggles randomly -> the same byte stream is received, and tx_data never changes while valid and not ready.
REQ-037 Overrun: a second capture is sent 5 cycles after the first -> only one frame is received, overrun=1, and the next frame's counter reads 00000002.
REQ-038 Snapshot isolation: pulses changes to 16'hFFFF during transmission -> the payload is still "1234" and the checksum is 26.
REQ-039 Reset after the 10th byte -> tx_valid=0 the next cycle; the next capture yields a frame with header "AA55000200000001".
REQ-040 Width: RESOLUTION=10, pulses word=10'h3FF -> the word is sent as "3FF" (NIB=3).
